jtframe_ddr_resp: RTL and testbench
===================================

# jtframe_ddr_resp

Responder (memory side) for the DDRAM burst port driven by line-frame-buffer and other DDR initiators. It accepts burst write and burst read commands, stores 64-bit words with byte enables in on-chip RAM, and returns read bursts with programmable latency. It lets initiators run on targets without a DDR controller and gives verification benches a cycle-exact DDR model. A `stall` input injects back-pressure.

## Interface
Parameters:
- `AW`, 12, word-address bits of the internal RAM (2^AW × 64 bit)
- `BASE`, 4'd3, value `ddram_addr[31:28]` must match for an access to hit the RAM
- `RDLAT`, 4, cycles from read acceptance to first data beat (legal range 2..15)

Ports (one clock; reset is asynchronous and active-high):
- `rst` in 1: asynchronous active-high reset
- `clk` in 1: clock; all ports synchronous to it
- `ddram_busy` out 1: waitrequest; command/beat transfers only when 0
- `ddram_burstcnt` in 8: burst length in 64-bit beats, sampled on command
- `ddram_addr` in 29 [31:3]: word address, sampled on command
- `ddram_rd` in 1: read command
- `ddram_we` in 1: write command/beat
- `ddram_din` in 64: write data
- `ddram_be` in 8: byte enables per write beat
- `ddram_dout` out 64: read data
- `ddram_dout_ready` out 1: read data valid
- `stall` in 1: forces busy and pauses read beats
- `err` out 1: sticky protocol-error flag, cleared only by reset

## Operation
- States: IDLE, WRITE, READ (RDLAT wait then data phase). One-deep pending-read slot.
- Hit: `ddram_addr[31:28]==BASE`; RAM word = `ddram_addr[AW+2:3]`; miss writes are dropped, miss reads return 0 (still full burst length).
- `burstcnt==0`: treated as 1, `err` set.
- Write: in IDLE, `we & ~busy` starts a burst; first beat is that cycle. Each later `we & ~busy` cycle stores one beat at next address. Bytes with `be[i]=0` unchanged. After `burstcnt` beats → IDLE. `we` low mid-burst just inserts gaps.
- Read: `rd & ~busy` in IDLE or data phase is accepted. In IDLE, → READ. In READ, command goes to pending slot; taken immediately when current burst finishes, so bursts stream back-to-back with no gap and no second RDLAT.
- Address increments by 1 word per beat, wraps modulo 2^AW.
- `busy` = `rst` | `stall` | pending slot full. Writes do not raise busy.
- Invariant: `dout_ready` never 1 while `busy` is 1; stall freezes beat counter, data resumes on next beat.
- `dout` holds last beat when `dout_ready`=0.
- Protocol errors (set `err`, ignore offending command): `rd` and `we` together in IDLE (write wins), `rd` during WRITE, `we` during READ.
- Reset mid-burst: burst abandoned, pending slot cleared, RAM contents kept.

## Timing
- Reset values: `ddram_busy`=1, `ddram_dout_ready`=0, `ddram_dout`=0, `err`=0; state IDLE. `busy` falls at first clock edge after `rst` released, when `stall`=0.
- Read accepted at edge E: beat k valid in cycle after edge E+RDLAT+k, when no stall.
- Pending command accepted before the last beat of the current burst: its beat 0 follows the last beat in the next cycle.
- Write beat at edge E is readable by a read accepted at edge E+1.
- `stall` reaches `busy`/beat pausing combinationally or within one cycle. The choice is documented in the RTL header and must keep the invariant.

## Test plan
- Write 128 beats at word 0x000, data=index, be=0xFF, then read 128 → `dout_ready` 128 times, data 0..127, first beat RDLAT cycles after accept.
- Write word 5 with be=0x03 data 0xFFFF over prior 0x1122334455667788 → readback 0x112233445566FFFF.
- Two reads of 128, second issued at beat 127 of the first (line-buffer pattern) → 256 contiguous beats, no gap, `err`=0.
- Random `stall` during read of 64 → `dout_ready` never with `busy`=1, all 64 beats in order.
- Read at `ddram_addr[31:28]`=2 with burstcnt 4 → four beats of 0. Simultaneous `rd`/`we` → write performed, `err`=1.
- Assert `rst` at beat 10 of 128-beat read → `dout_ready`=0, `busy`=1 during reset. New read after reset returns pre-reset RAM data.

Source files
------------

// File: rtl/jtframe_ddr_resp.sv
// jtframe_ddr_resp: memory-side responder for the DDRAM burst port.
// Stores 64-bit words with byte enables in on-chip RAM and returns read
// bursts after RDLAT cycles, with a one-deep pending-read slot so that
// back-to-back bursts stream without a gap.
//
// stall timing: stall is registered before it reaches ddram_busy (busy
// follows stall one cycle late), but it gates read beats at the very next
// edge. A beat is therefore never presented in a cycle where busy is high.
// For the same reason a held pending read raises busy only in cycles that
// show no beat; a read arriving while a beat is shown and the slot is
// already full is dropped and flags err.
module jtframe_ddr_resp #(
    parameter int unsigned AW    = 12,
    parameter logic [3:0]  BASE  = 4'd3,
    parameter int unsigned RDLAT = 4
) (
    input  logic        rst,
    input  logic        clk,
    output logic        ddram_busy,
    input  logic [7:0]  ddram_burstcnt,
    input  logic [28:0] ddram_addr,
    input  logic        ddram_rd,
    input  logic        ddram_we,
    input  logic [63:0] ddram_din,
    input  logic [7:0]  ddram_be,
    output logic [63:0] ddram_dout,
    output logic        ddram_dout_ready,
    input  logic        stall,
    output logic        err
);

    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] { IDLE, WRITE, READ } state_t;

    state_t        state_q;
    logic          rdy_q;
    logic          stall_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    left_q;
    logic          hit_q;
    logic [3:0]    wait_q;
    logic          pend_q;
    logic [AW-1:0] pend_addr_q;
    logic [7:0]    pend_cnt_q;
    logic          pend_hit_q;
    logic [63:0]   dout_q;
    logic          dout_ready_q;
    logic          err_q;

    logic [63:0]   mem [DEPTH];

    logic          hit_c;
    logic [AW-1:0] word_c;
    logic [7:0]    cnt_c;
    logic          zero_c;
    logic          busy_c;
    logic          wr_go_c;
    logic          rd_go_c;
    logic          beat_c;
    logic          last_c;
    logic          mem_we_c;
    logic [AW-1:0] mem_addr_c;
    logic          unused_c;

    // Command decode, handshake and RAM write strobe
    always_comb begin
        hit_c      = ddram_addr[28:25] == BASE;
        word_c     = ddram_addr[AW-1:0];
        zero_c     = ddram_burstcnt == 8'd0;
        cnt_c      = zero_c ? 8'd1 : ddram_burstcnt;
        busy_c     = ~rdy_q | stall_q | (pend_q & ~dout_ready_q);
        wr_go_c    = ddram_we & ~busy_c;
        rd_go_c    = ddram_rd & ~busy_c;
        beat_c     = (state_q == READ) && (wait_q == 4'd0) && !stall;
        last_c     = beat_c && (left_q == 8'd1);
        mem_we_c   = 1'b0;
        mem_addr_c = addr_q;
        if (wr_go_c) begin
            if (state_q == IDLE) begin
                mem_we_c   = hit_c;
                mem_addr_c = word_c;
            end else if (state_q == WRITE) begin
                mem_we_c   = hit_q;
            end
        end
        unused_c   = ^ddram_addr[24:AW];
    end

    assign ddram_busy       = busy_c;
    assign ddram_dout       = dout_q;
    assign ddram_dout_ready = dout_ready_q;
    assign err              = err_q;

    // Byte-enabled RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < 8; i++) begin
                if (ddram_be[i]) mem[mem_addr_c][i*8 +: 8] <= ddram_din[i*8 +: 8];
            end
        end
    end

    // Burst sequencer: write bursts, read latency, beat issue and pending slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rdy_q        <= 1'b0;
            stall_q      <= 1'b0;
            addr_q       <= '0;
            left_q       <= 8'd0;
            hit_q        <= 1'b0;
            wait_q       <= 4'd0;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            pend_cnt_q   <= 8'd0;
            pend_hit_q   <= 1'b0;
            dout_q       <= 64'd0;
            dout_ready_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rdy_q        <= 1'b1;
            stall_q      <= stall;
            dout_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_go_c) begin
                        if (ddram_rd || zero_c) err_q <= 1'b1;
                        addr_q <= word_c + AW'(1);
                        left_q <= cnt_c - 8'd1;
                        hit_q  <= hit_c;
                        if (cnt_c != 8'd1) state_q <= WRITE;
                    end else if (rd_go_c) begin
                        if (zero_c) err_q <= 1'b1;
                        addr_q  <= word_c;
                        left_q  <= cnt_c;
                        hit_q   <= hit_c;
                        wait_q  <= 4'(RDLAT - 1);
                        state_q <= READ;
                    end
                end
                WRITE: begin
                    if (rd_go_c) err_q <= 1'b1;
                    if (wr_go_c) begin
                        addr_q <= addr_q + AW'(1);
                        left_q <= left_q - 8'd1;
                        if (left_q == 8'd1) state_q <= IDLE;
                    end
                end
                READ: begin
                    if (wr_go_c || (rd_go_c && zero_c)) err_q <= 1'b1;
                    if (wait_q != 4'd0) wait_q <= wait_q - 4'd1;
                    if (beat_c) begin
                        dout_q       <= hit_q ? mem[addr_q] : 64'd0;
                        dout_ready_q <= 1'b1;
                        addr_q       <= addr_q + AW'(1);
                        left_q       <= left_q - 8'd1;
                    end
                    if (last_c) begin
                        if (pend_q) begin
                            addr_q <= pend_addr_q;
                            left_q <= pend_cnt_q;
                            hit_q  <= pend_hit_q;
                            pend_q <= rd_go_c;
                            if (rd_go_c) begin
                                pend_addr_q <= word_c;
                                pend_cnt_q  <= cnt_c;
                                pend_hit_q  <= hit_c;
                            end
                        end else if (rd_go_c) begin
                            addr_q <= word_c;
                            left_q <= cnt_c;
                            hit_q  <= hit_c;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (rd_go_c) begin
                        if (pend_q) begin
                            err_q <= 1'b1;
                        end else begin
                            pend_q      <= 1'b1;
                            pend_addr_q <= word_c;
                            pend_cnt_q  <= cnt_c;
                            pend_hit_q  <= hit_c;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_ddr_resp.sv
// Scoreboard bench for jtframe_ddr_resp: a word-array model of the RAM
// produces the expected beats of every accepted read; a negedge monitor
// pops and compares each presented beat (data and, where fixed, cycle).
module tb_jtframe_ddr_resp;

    localparam int unsigned AW    = 12;
    localparam int unsigned RDLAT = 4;
    localparam logic [3:0]  BASE  = 4'd3;
    localparam int unsigned DEPTH = 1 << AW;

    logic        rst;
    logic        clk;
    logic        ddram_busy;
    logic [7:0]  ddram_burstcnt;
    logic [28:0] ddram_addr;
    logic        ddram_rd;
    logic        ddram_we;
    logic [63:0] ddram_din;
    logic [7:0]  ddram_be;
    logic [63:0] ddram_dout;
    logic        ddram_dout_ready;
    logic        stall = 1'b0;
    logic        err;

    jtframe_ddr_resp #(.AW(AW), .BASE(BASE), .RDLAT(RDLAT)) dut (
        .rst             (rst),
        .clk             (clk),
        .ddram_busy      (ddram_busy),
        .ddram_burstcnt  (ddram_burstcnt),
        .ddram_addr      (ddram_addr),
        .ddram_rd        (ddram_rd),
        .ddram_we        (ddram_we),
        .ddram_din       (ddram_din),
        .ddram_be        (ddram_be),
        .ddram_dout      (ddram_dout),
        .ddram_dout_ready(ddram_dout_ready),
        .stall           (stall),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] ref_mem [DEPTH];
    int          errors = 0;
    int          checks = 0;
    int          beats_seen = 0;
    bit          stall_rand = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic logic [28:0] mk_addr(input logic [3:0] base, input int unsigned word);
        return {base, 25'(word % DEPTH)};
    endfunction

    // Expected beats of a read: consecutive words with wrap, zeros on a miss
    function automatic void push_read(input logic [28:0] a, input int n, input int c0);
        int unsigned w;
        bit          hit;
        int          len;
        w   = 32'(a[AW-1:0]);
        hit = (a[28:25] == BASE);
        len = (n == 0) ? 1 : n;
        for (int k = 0; k < len; k++) begin
            exp_t e;
            e.data = hit ? ref_mem[(w + k) % DEPTH] : 64'd0;
            e.cyc  = (c0 < 0) ? -1 : c0 + k;
            exp_q.push_back(e);
        end
    endfunction

    // Monitor: every presented beat must be expected, in order, and not under busy
    always @(negedge clk) begin
        if (ddram_dout_ready === 1'b1) begin
            exp_t e;
            beats_seen++;
            check("ready_while_busy", {63'd0, ddram_busy}, 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h want none", ddram_dout);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", ddram_dout, e.data);
                if (e.cyc >= 0) check("beat_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Random back-pressure generator
    always @(posedge clk) begin
        #1;
        stall = stall_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
    end

    task automatic wait_free(input string name);
        int t = 0;
        while (ddram_busy !== 1'b0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL %s: got busy want idle within 500 cycles", name);
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // Issue one read command; returns the edge count at which it was accepted
    task automatic rd_cmd(input logic [28:0] a, input int n, output int acc);
        ddram_rd       = 1'b1;
        ddram_addr     = a;
        ddram_burstcnt = 8'(n);
        wait_free("rd_accept");
        @(posedge clk); #1;
        acc      = cyc;
        ddram_rd = 1'b0;
    endtask

    // Write burst; mode 0: data=index be=FF, 1: random data/be, 2: constant
    task automatic wr_burst(input logic [28:0] a, input int n, input int mode,
                            input logic [63:0] dconst, input logic [7:0] beconst, input bit gaps);
        int unsigned w;
        bit          hit;
        w   = 32'(a[AW-1:0]);
        hit = (a[28:25] == BASE);
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    ddram_we = 1'b0;
                    @(posedge clk); #1;
                end
            end
            ddram_we       = 1'b1;
            ddram_addr     = a;
            ddram_burstcnt = 8'(n);
            case (mode)
                0:       begin ddram_din = 64'(k);                 ddram_be = 8'hFF; end
                1:       begin ddram_din = {$urandom, $urandom};   ddram_be = 8'($urandom); end
                default: begin ddram_din = dconst;                 ddram_be = beconst; end
            endcase
            wait_free("wr_accept");
            @(posedge clk); #1;
            if (hit) begin
                for (int b = 0; b < 8; b++)
                    if (ddram_be[b]) ref_mem[(w + k) % DEPTH][b*8 +: 8] = ddram_din[b*8 +: 8];
            end
        end
        ddram_we = 1'b0;
    endtask

    task automatic reset_seq();
        rst = 1'b1;
        #1;
        check("rst_busy", {63'd0, ddram_busy}, 64'd1);
        check("rst_ready", {63'd0, ddram_dout_ready}, 64'd0);
        check("rst_dout", ddram_dout, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check("busy_before_edge", {63'd0, ddram_busy}, 64'd1);
        @(posedge clk); #1;
        check("busy_after_edge", {63'd0, ddram_busy}, 64'd0);
    endtask

    initial begin
        int acc, acc2, b0, t;
        logic [63:0] d;
        ddram_rd = 1'b0; ddram_we = 1'b0; ddram_addr = '0; ddram_burstcnt = 8'd0;
        ddram_din = '0; ddram_be = '0;
        reset_seq();

        // 128-beat write of the index, read back with fixed latency
        wr_burst(mk_addr(BASE, 0), 128, 0, 64'd0, 8'h00, 1'b0);
        rd_cmd(mk_addr(BASE, 0), 128, acc);
        push_read(mk_addr(BASE, 0), 128, acc + RDLAT);
        drain("drain_seq128");

        // Partial byte-enable write over a full word
        wr_burst(mk_addr(BASE, 5), 1, 2, 64'h1122334455667788, 8'hFF, 1'b0);
        wr_burst(mk_addr(BASE, 5), 1, 2, 64'h000000000000FFFF, 8'h03, 1'b0);
        rd_cmd(mk_addr(BASE, 5), 1, acc);
        push_read(mk_addr(BASE, 5), 1, acc + RDLAT);
        drain("drain_be");

        // Line-buffer pattern: second read issued while beat 126 is shown
        wr_burst(mk_addr(BASE, 128), 128, 1, 64'd0, 8'h00, 1'b1);
        rd_cmd(mk_addr(BASE, 0), 128, acc);
        push_read(mk_addr(BASE, 0), 128, acc + RDLAT);
        t = 0;
        while (cyc < acc + RDLAT + 126 && t < 1000) begin @(posedge clk); #1; t++; end
        rd_cmd(mk_addr(BASE, 128), 128, acc2);
        push_read(mk_addr(BASE, 128), 128, acc + RDLAT + 128);
        drain("drain_stream");
        check("err_stream", {63'd0, err}, 64'd0);

        // Second read parked in the pending slot during the first read's latency
        rd_cmd(mk_addr(BASE, 200), 8, acc);
        push_read(mk_addr(BASE, 200), 8, acc + RDLAT);
        rd_cmd(mk_addr(BASE, 300), 8, acc2);
        push_read(mk_addr(BASE, 300), 8, acc + RDLAT + 8);
        drain("drain_pending");
        check("err_pending", {63'd0, err}, 64'd0);

        // Random stall during a 64-beat read
        stall_rand = 1'b1;
        rd_cmd(mk_addr(BASE, 64), 64, acc);
        push_read(mk_addr(BASE, 64), 64, -1);
        drain("drain_stall");
        stall_rand = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("err_stall", {63'd0, err}, 64'd0);

        // Miss read returns zeros for the full length
        rd_cmd(mk_addr(4'd2, 10), 4, acc);
        push_read(mk_addr(4'd2, 10), 4, acc + RDLAT);
        drain("drain_miss");

        // Simultaneous rd and we: write wins, err set
        d = {$urandom, $urandom};
        ddram_rd = 1'b1;
        wr_burst(mk_addr(BASE, 7), 1, 2, d, 8'hFF, 1'b0);
        ddram_rd = 1'b0;
        check("err_rdwe", {63'd0, err}, 64'd1);
        rd_cmd(mk_addr(BASE, 7), 1, acc);
        push_read(mk_addr(BASE, 7), 1, acc + RDLAT);
        drain("drain_rdwe");

        // Address wrap at the top of the RAM
        wr_burst(mk_addr(BASE, DEPTH - 2), 4, 1, 64'd0, 8'h00, 1'b1);
        rd_cmd(mk_addr(BASE, DEPTH - 2), 4, acc);
        push_read(mk_addr(BASE, DEPTH - 2), 4, acc + RDLAT);
        drain("drain_wrap");

        // Reset in the middle of a 128-beat read
        b0 = beats_seen;
        rd_cmd(mk_addr(BASE, 0), 128, acc);
        push_read(mk_addr(BASE, 0), 128, acc + RDLAT);
        t = 0;
        while (beats_seen < b0 + 10 && t < 1000) begin @(posedge clk); #1; t++; end
        check("beats_before_reset", 64'(beats_seen - b0), 64'd10);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_ready", {63'd0, ddram_dout_ready}, 64'd0);
        check("midrst_busy", {63'd0, ddram_busy}, 64'd1);
        repeat (2) begin @(posedge clk); #1; end
        check("midrst_busy_hold", {63'd0, ddram_busy}, 64'd1);
        check("midrst_err", {63'd0, err}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("postrst_busy", {63'd0, ddram_busy}, 64'd0);
        rd_cmd(mk_addr(BASE, 0), 16, acc);
        push_read(mk_addr(BASE, 0), 16, acc + RDLAT);
        drain("drain_postrst");

        // Zero burst count behaves as one beat and flags err
        rd_cmd(mk_addr(BASE, 3), 0, acc);
        push_read(mk_addr(BASE, 3), 0, acc + RDLAT);
        drain("drain_zero");
        check("err_zero", {63'd0, err}, 64'd1);

        check("leftover_beats", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
